// File: rtl/wb_write_queue.sv
// wb_write_queue: in-order writeback queue feeding the register-file write port.
// Results from the load unit (higher priority) and the ALU are accepted one
// per cycle into a circular FIFO, then drained one per cycle into a registered
// write port (writeEnable/wRegNum/wDataIn). Writes to x0 are dropped at entry.
// Optional feature macro: WB_BYPASS_EN builds the combinational bypass search
// so decode read ports can see results that are still queued or in the output
// register. Without it the bypass outputs are tied to zero.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     chip_en,
    input  logic                     flush,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [4:0]               alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [4:0]               ld_rd,
    input  logic [XLEN-1:0]          ld_data,
    output logic                     writeEnable,
    output logic [4:0]               wRegNum,
    output logic [XLEN-1:0]          wDataIn,
    input  logic [4:0]               regNum0,
    input  logic [4:0]               regNum1,
    output logic                     byp0_hit,
    output logic [XLEN-1:0]          byp0_data,
    output logic                     byp1_hit,
    output logic [XLEN-1:0]          byp1_data,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1'b1);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1'b1);

    // Queue storage and bookkeeping
    logic [4:0]      rd_mem_r   [DEPTH];
    logic [XLEN-1:0] data_mem_r [DEPTH];
    logic [AW-1:0]   head_r;
    logic [AW-1:0]   tail_r;
    logic [AW:0]     occ_r;

    // Output (register-file write) stage
    logic            we_r;
    logic [4:0]      wreg_r;
    logic [XLEN-1:0] wdata_r;

    // Handshake / control decode
    logic            full_s;
    logic            empty_s;
    logic            accept_ready_s;
    logic            take_ld_s;
    logic            take_alu_s;
    logic            push_s;
    logic [4:0]      push_rd_s;
    logic [XLEN-1:0] push_data_s;
    logic            pop_s;

    // Readiness depends only on the registered count, never on a same-cycle pop.
    assign full_s         = (occ_r == FULL_COUNT);
    assign empty_s        = (occ_r == {(AW+1){1'b0}});
    assign accept_ready_s = chip_en & ~full_s & ~flush;
    assign ld_ready       = accept_ready_s;
    assign alu_ready      = accept_ready_s & ~ld_valid;
    assign take_ld_s      = ld_valid & accept_ready_s;
    assign take_alu_s     = alu_valid & accept_ready_s & ~ld_valid;
    assign pop_s          = chip_en & ~empty_s & ~flush;

    assign occupancy   = occ_r;
    assign writeEnable = we_r;
    assign wRegNum     = wreg_r;
    assign wDataIn     = wdata_r;

    // Select the accepted source; an x0 destination completes the handshake but enqueues nothing.
    always_comb begin
        push_s      = 1'b0;
        push_rd_s   = 5'd0;
        push_data_s = {XLEN{1'b0}};
        if (take_ld_s) begin
            push_s      = (ld_rd != 5'd0);
            push_rd_s   = ld_rd;
            push_data_s = ld_data;
        end else if (take_alu_s) begin
            push_s      = (alu_rd != 5'd0);
            push_rd_s   = alu_rd;
            push_data_s = alu_data;
        end else begin
            push_s      = 1'b0;
            push_rd_s   = 5'd0;
            push_data_s = {XLEN{1'b0}};
        end
    end

    // Queue entry storage: written at the tail on every non-x0 accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem_r[i]   <= 5'd0;
                data_mem_r[i] <= {XLEN{1'b0}};
            end
        end else if (push_s) begin
            rd_mem_r[tail_r]   <= push_rd_s;
            data_mem_r[tail_r] <= push_data_s;
        end
    end

    // Head/tail pointers and occupancy counter; flush empties the queue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_r <= {AW{1'b0}};
            tail_r <= {AW{1'b0}};
            occ_r  <= {(AW+1){1'b0}};
        end else if (flush) begin
            head_r <= {AW{1'b0}};
            tail_r <= {AW{1'b0}};
            occ_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PTR_ONE;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + CNT_ONE;
                2'b01:   occ_r <= occ_r - CNT_ONE;
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Output register: load the head on a pop, otherwise drop enable and hold address/data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_r    <= 1'b0;
            wreg_r  <= 5'd0;
            wdata_r <= {XLEN{1'b0}};
        end else begin
            we_r <= pop_s;
            if (pop_s) begin
                wreg_r  <= rd_mem_r[head_r];
                wdata_r <= data_mem_r[head_r];
            end else begin
                wreg_r  <= wreg_r;
                wdata_r <= wdata_r;
            end
        end
    end

`ifdef WB_BYPASS_EN
    logic [XLEN:0] byp0_s;
    logic [XLEN:0] byp1_s;

    // Returns {hit, data}. Candidates are visited oldest first (output register,
    // then head..tail) so the youngest matching entry is the one left standing.
    function automatic logic [XLEN:0] byp_lookup(input logic [4:0] probe);
        logic            hit;
        logic [XLEN-1:0] data;
        logic [AW-1:0]   idx;
        hit  = 1'b0;
        data = {XLEN{1'b0}};
        idx  = head_r;
        if (probe != 5'd0) begin
            if (we_r && (wreg_r == probe)) begin
                hit  = 1'b1;
                data = wdata_r;
            end else begin
                hit  = 1'b0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = head_r + AW'(i);
                if (((AW+1)'(i) < occ_r) && (rd_mem_r[idx] == probe)) begin
                    hit  = 1'b1;
                    data = data_mem_r[idx];
                end else begin
                    hit  = hit;
                end
            end
        end else begin
            hit  = 1'b0;
            data = {XLEN{1'b0}};
        end
        return {hit, data};
    endfunction

    // Combinational bypass search for both read-port probes.
    always_comb begin
        byp0_s = byp_lookup(regNum0);
        byp1_s = byp_lookup(regNum1);
    end

    assign byp0_hit  = byp0_s[XLEN];
    assign byp0_data = byp0_s[XLEN-1:0];
    assign byp1_hit  = byp1_s[XLEN];
    assign byp1_data = byp1_s[XLEN-1:0];
`else
    // Bypass not built: decode must stall on pending writes.
    logic unused_probe_s;
    assign unused_probe_s = ^{regNum0, regNum1};
    assign byp0_hit  = 1'b0;
    assign byp0_data = {XLEN{1'b0}};
    assign byp1_hit  = 1'b0;
    assign byp1_data = {XLEN{1'b0}};
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Self-checking bench for wb_write_queue. A queue-based reference model tracks
// the pending entries and the expected write-port state cycle by cycle.
// Honours WB_BYPASS_EN for the bypass expectations.
module tb_wb_write_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, chip_en, flush;
    logic            alu_valid, alu_ready, ld_valid, ld_ready;
    logic [4:0]      alu_rd, ld_rd;
    logic [XLEN-1:0] alu_data, ld_data;
    logic            writeEnable;
    logic [4:0]      wRegNum;
    logic [XLEN-1:0] wDataIn;
    logic [4:0]      regNum0, regNum1;
    logic            byp0_hit, byp1_hit;
    logic [XLEN-1:0] byp0_data, byp1_data;
    logic [2:0]      occupancy;

    wb_write_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .chip_en(chip_en), .flush(flush),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .writeEnable(writeEnable), .wRegNum(wRegNum), .wDataIn(wDataIn),
        .regNum0(regNum0), .regNum1(regNum1),
        .byp0_hit(byp0_hit), .byp0_data(byp0_data),
        .byp1_hit(byp1_hit), .byp1_data(byp1_data),
        .occupancy(occupancy)
    );

    typedef struct packed { logic [4:0] rd; logic [31:0] data; } ent_t;

    ent_t        q[$];
    logic        m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic [4:0]  obs[$];
    int          tests  = 0;
    int          failed = 0;

    function automatic logic [2:0] exp_occ();
        return 3'(q.size());
    endfunction

    function automatic logic exp_ld_rdy();
        return chip_en && (q.size() < DEPTH) && !flush;
    endfunction

    function automatic logic exp_alu_rdy();
        return exp_ld_rdy() && !ld_valid;
    endfunction

    // Youngest queued entry first, then the in-flight write.
    function automatic logic [32:0] model_byp(input logic [4:0] rn);
`ifdef WB_BYPASS_EN
        if (rn == 5'd0) return 33'd0;
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].rd == rn) return {1'b1, q[i].data};
        if (m_we && m_rd == rn) return {1'b1, m_data};
        return 33'd0;
`else
        return 33'd0;
`endif
    endfunction

    function automatic void model_reset();
        q.delete();
        m_we = 1'b0; m_rd = 5'd0; m_data = 32'd0;
    endfunction

    task automatic idle();
        alu_valid = 1'b0; ld_valid = 1'b0; flush = 1'b0;
        alu_rd = 5'd0; ld_rd = 5'd0; alu_data = 32'd0; ld_data = 32'd0;
    endtask

    // Advance one clock: update the model from the current inputs, then move the DUT.
    task automatic step();
        logic rdy;
        rdy = exp_ld_rdy();
        if (flush) begin
            q.delete();
            m_we = 1'b0;
        end else begin
            if (chip_en && q.size() > 0) begin
                m_we = 1'b1; m_rd = q[0].rd; m_data = q[0].data;
                void'(q.pop_front());
            end else begin
                m_we = 1'b0;
            end
            if (ld_valid && rdy) begin
                if (ld_rd != 5'd0) q.push_back('{ld_rd, ld_data});
            end else if (alu_valid && rdy) begin
                if (alu_rd != 5'd0) q.push_back('{alu_rd, alu_data});
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (writeEnable === 1'b1) obs.push_back(wRegNum);
    endtask

    task automatic test_reset();
        reset = 1'b0; chip_en = 1'b1; idle();
        regNum0 = 5'd5; regNum1 = 5'd9;
        model_reset();
        @(negedge clk); @(negedge clk);
        tests++;
        if ({writeEnable, wRegNum, wDataIn, occupancy, byp0_hit, byp1_hit, byp0_data, byp1_data} !== 106'd0) begin
            failed++;
            $display("FAIL reset: we=%b rd=%0d data=%h occ=%0d h0=%b h1=%b, required all zero",
                     writeEnable, wRegNum, wDataIn, occupancy, byp0_hit, byp1_hit);
        end
        reset = 1'b1;
    endtask

    task automatic test_single_alu();
        idle();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_00A5;
        #1;
        tests++;
        if (alu_ready !== 1'b1) begin failed++; $display("FAIL single ready: got %b need 1", alu_ready); end
        step(); idle();
        tests++;
        if ({writeEnable, occupancy} !== {1'b0, 3'd1}) begin
            failed++; $display("FAIL single queued: we=%b occ=%0d need 0/1", writeEnable, occupancy);
        end
        step();
        tests++;
        if ({writeEnable, wRegNum, wDataIn, occupancy} !== {1'b1, 5'd5, 32'h0000_00A5, 3'd0}) begin
            failed++; $display("FAIL single write: we=%b rd=%0d data=%h occ=%0d need 1/5/a5/0",
                               writeEnable, wRegNum, wDataIn, occupancy);
        end
        step();
        tests++;
        if ({writeEnable, wRegNum, wDataIn} !== {1'b0, 5'd5, 32'h0000_00A5}) begin
            failed++; $display("FAIL single hold: we=%b rd=%0d data=%h need 0/5/a5", writeEnable, wRegNum, wDataIn);
        end
    endtask

    task automatic test_priority_x0();
        idle(); obs.delete();
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h33;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
        #1;
        tests++;
        if ({ld_ready, alu_ready} !== 2'b10) begin
            failed++; $display("FAIL prio ready: ld=%b alu=%b need 1/0", ld_ready, alu_ready);
        end
        step();
        ld_valid = 1'b0;
        step();
        alu_rd = 5'd0; alu_data = 32'hDEAD;
        #1;
        tests++;
        if (alu_ready !== 1'b1) begin failed++; $display("FAIL x0 ready: got %b need 1", alu_ready); end
        step();
        tests++;
        if ({writeEnable, wRegNum, wDataIn, occupancy} !== {m_we, m_rd, m_data, exp_occ()}) begin
            failed++; $display("FAIL x0 out: got %b/%0d/%h/%0d need %b/%0d/%h/%0d",
                writeEnable, wRegNum, wDataIn, occupancy, m_we, m_rd, m_data, exp_occ());
        end
        idle();
        for (int i = 0; i < 3; i++) step();
        tests++;
        if (obs.size() != 2 || obs[0] != 5'd3 || obs[1] != 5'd4) begin
            failed++; $display("FAIL prio order: got %0d writes (first %0d) need 3,4", obs.size(),
                               obs.size() > 0 ? obs[0] : 5'd0);
        end
    endtask

    task automatic test_full_wrap();
        int nxt;
        int cyc;
        logic acc;
        idle(); obs.delete();
        nxt = 1; cyc = 0;
        while (nxt <= 8 && cyc < 200) begin
            chip_en   = ($urandom_range(0, 3) != 0);
            alu_valid = 1'b1; alu_rd = 5'(nxt); alu_data = 32'(nxt) * 32'h0101_0101;
            #1;
            tests++;
            if ({ld_ready, alu_ready} !== {exp_ld_rdy(), exp_alu_rdy()}) begin
                failed++; $display("FAIL wrap ready: got %b%b need %b%b", ld_ready, alu_ready,
                                   exp_ld_rdy(), exp_alu_rdy());
            end
            acc = exp_alu_rdy();
            step();
            tests++;
            if ({writeEnable, wRegNum, wDataIn, occupancy} !== {m_we, m_rd, m_data, exp_occ()}) begin
                failed++; $display("FAIL wrap out: got %b/%0d/%h/%0d need %b/%0d/%h/%0d",
                    writeEnable, wRegNum, wDataIn, occupancy, m_we, m_rd, m_data, exp_occ());
            end
            if (acc) nxt++;
            cyc++;
        end
        tests++;
        if (nxt <= 8) begin failed++; $display("FAIL wrap timeout: pushed %0d need 8", nxt - 1); end
        chip_en = 1'b1; idle();
        for (int i = 0; i < 4; i++) step();
        tests++;
        if (obs.size() != 8) begin
            failed++; $display("FAIL wrap count: got %0d writes need 8", obs.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                tests++;
                if (obs[i] != 5'(i + 1)) begin
                    failed++; $display("FAIL wrap order[%0d]: got %0d need %0d", i, obs[i], i + 1);
                end
            end
        end
    endtask

    task automatic test_bypass();
        logic [32:0] e22;
`ifdef WB_BYPASS_EN
        e22 = {1'b1, 32'h22};
`else
        e22 = 33'd0;
`endif
        idle(); chip_en = 1'b1;
        regNum0 = 5'd7; regNum1 = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h11;
        step();
        alu_data = 32'h22;
        step();
        idle();
        #1;
        tests++;
        if ({byp0_hit, byp0_data} !== e22 || {byp0_hit, byp0_data} !== model_byp(regNum0)) begin
            failed++; $display("FAIL byp young: got %b/%h need %h", byp0_hit, byp0_data, e22);
        end
        tests++;
        if ({byp1_hit, byp1_data} !== 33'd0) begin
            failed++; $display("FAIL byp x0: got %b/%h need 0/0", byp1_hit, byp1_data);
        end
        step();
        #1;
        tests++;
        if ({byp0_hit, byp0_data} !== e22) begin
            failed++; $display("FAIL byp outreg: got %b/%h need %h", byp0_hit, byp0_data, e22);
        end
        step();
        #1;
        tests++;
        if ({byp0_hit, byp0_data} !== 33'd0) begin
            failed++; $display("FAIL byp miss: got %b/%h need 0/0", byp0_hit, byp0_data);
        end
    endtask

    task automatic test_flush();
        idle(); obs.delete(); chip_en = 1'b1;
        alu_valid = 1'b1;
        for (int i = 10; i < 13; i++) begin
            alu_rd = 5'(i); alu_data = 32'(i);
            step();
        end
        tests++;
        if ({writeEnable, wRegNum, occupancy} !== {1'b1, 5'd11, 3'd1}) begin
            failed++; $display("FAIL flush pre: we=%b rd=%0d occ=%0d need 1/11/1", writeEnable, wRegNum, occupancy);
        end
        alu_rd = 5'd13; flush = 1'b1;
        #1;
        tests++;
        if ({ld_ready, alu_ready} !== 2'b00) begin
            failed++; $display("FAIL flush ready: got %b%b need 00", ld_ready, alu_ready);
        end
        step();
        tests++;
        if ({writeEnable, occupancy} !== {1'b0, 3'd0}) begin
            failed++; $display("FAIL flush post: we=%b occ=%0d need 0/0", writeEnable, occupancy);
        end
        idle();
        step();
        tests++;
        if (writeEnable !== 1'b0 || obs.size() != 2 || obs[1] != 5'd11) begin
            failed++; $display("FAIL flush drain: we=%b writes=%0d need 0 and 10,11", writeEnable, obs.size());
        end
    endtask

    task automatic test_async_reset();
        idle(); chip_en = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h20;
        step();
        alu_rd = 5'd21; alu_data = 32'h21;
        step();
        #2 reset = 1'b0;
        #1;
        model_reset();
        tests++;
        if ({writeEnable, wRegNum, wDataIn, occupancy} !== 40'd0) begin
            failed++; $display("FAIL async reset: we=%b rd=%0d data=%h occ=%0d need zero",
                               writeEnable, wRegNum, wDataIn, occupancy);
        end
        idle();
        @(negedge clk);
        reset = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        step();
        idle();
        step();
        tests++;
        if ({writeEnable, wRegNum, wDataIn} !== {1'b1, 5'd9, 32'h99}) begin
            failed++; $display("FAIL post reset: we=%b rd=%0d data=%h need 1/9/99", writeEnable, wRegNum, wDataIn);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            chip_en   = ($urandom_range(0, 7) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            ld_valid  = ($urandom_range(0, 2) == 0);
            alu_valid = ($urandom_range(0, 1) == 0);
            ld_rd     = 5'($urandom_range(0, 7));
            alu_rd    = 5'($urandom_range(0, 7));
            ld_data   = $urandom;
            alu_data  = $urandom;
            regNum0   = 5'($urandom_range(0, 7));
            regNum1   = 5'($urandom_range(0, 7));
            #1;
            tests++;
            if ({ld_ready, alu_ready, byp0_hit, byp0_data, byp1_hit, byp1_data} !==
                {exp_ld_rdy(), exp_alu_rdy(), model_byp(regNum0), model_byp(regNum1)}) begin
                failed++; $display("FAIL rand comb c%0d: rdy=%b%b b0=%b/%h b1=%b/%h need %b%b %h %h", c,
                    ld_ready, alu_ready, byp0_hit, byp0_data, byp1_hit, byp1_data,
                    exp_ld_rdy(), exp_alu_rdy(), model_byp(regNum0), model_byp(regNum1));
            end
            step();
            tests++;
            if ({writeEnable, wRegNum, wDataIn, occupancy} !== {m_we, m_rd, m_data, exp_occ()}) begin
                failed++; $display("FAIL rand out c%0d: got %b/%0d/%h/%0d need %b/%0d/%h/%0d", c,
                    writeEnable, wRegNum, wDataIn, occupancy, m_we, m_rd, m_data, exp_occ());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_priority_x0();
        test_full_wrap();
        test_bypass();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_write_queue.md
# wb_write_queue

Writeback-side producer for the register file's write port: collects results from the ALU and load unit, buffers them in an in-order queue, and drives `writeEnable`/`wRegNum`/`wDataIn` one entry per cycle. Sits between execute/memory and the `decode` register file. Optionally provides bypass lookups so the read ports see results still queued. Writes to x0 are dropped at entry.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2
- `XLEN`, 32: data width
- `clk` in 1: clock, rising edge
- `reset` in 1: asynchronous, active-low (asserted at 0)
- `chip_en` in 1: 0 freezes the block: no accept, no pop, state held
- `flush` in 1: synchronous; discards all queued entries
- `alu_valid` in 1, `alu_ready` out 1, `alu_rd` in 5, `alu_data` in XLEN: ALU result handshake
- `ld_valid` in 1, `ld_ready` out 1, `ld_rd` in 5, `ld_data` in XLEN: load result handshake
- `writeEnable` out 1, `wRegNum` out 5, `wDataIn` out XLEN: registered register-file write port
- `regNum0` in 5, `regNum1` in 5: bypass probe addresses, same as the read-port addresses
- `byp0_hit` out 1, `byp0_data` out XLEN, `byp1_hit` out 1, `byp1_data` out XLEN: bypass results
- `occupancy` out clog2(DEPTH)+1: queued entry count; excludes the output register

## Operation
- Circular FIFO with head/tail pointers; wrap modulo DEPTH; `occupancy` is a registered counter.
- Accept: at most one entry per cycle. Fixed priority is load over ALU.
  - `ld_ready` = `chip_en` & !full & !`flush`
  - `alu_ready` = `ld_ready` & !`ld_valid`
  - A handshake is valid & ready at the rising edge.
- rd==0: the handshake completes but nothing is enqueued, and `occupancy` is unchanged.
- Pop: when `chip_en` & !empty & !`flush`, the head moves into the output register. `writeEnable`=1 and `wRegNum`/`wDataIn` take the head values for the next cycle. Otherwise `writeEnable`=0 next cycle and `wRegNum`/`wDataIn` hold their values.
- Simultaneous push and pop: both happen and `occupancy` is unchanged.
- Ready is derived only from registered `occupancy`. When full, ready=0 even in a cycle that pops (no combinational pop→ready path).
- `flush`: at the edge, head=tail=0 and `occupancy`=0. The same-edge accept and pop are suppressed. The output register still completes its current write; next-cycle `writeEnable`=0.
- `chip_en`=0 with `writeEnable`=1: the output register's write completes at that edge, then `writeEnable`=0.
- Bypass (combinational):
  - Search order is the queue youngest→oldest, then the output register while `writeEnable`=1.
  - The first rd match returns hit=1 with its data.
  - regNum==0 never hits.
  - On a miss, hit=0 and data=0.

## Timing
- Reset values: `writeEnable`=0, `wRegNum`=0, `wDataIn`=0, `occupancy`=0, pointers=0, `byp*_hit`=0.
- Latency, empty queue: a handshake at edge k gives `writeEnable`=1 in the cycle after edge k+1. The register file commits at edge k+2.
- Throughput: one write per cycle sustained.
- Reset asserted mid-operation: all queued and output state is cleared immediately (asynchronous). Entries are lost; no write occurs.
- Reset deassertion is assumed synchronized upstream. The first accept is possible at the first edge after reset goes high.

## Configuration
- `WB_BYPASS_EN` defined: bypass search logic built as above.
- `WB_BYPASS_EN` not defined: no search logic; `byp0_hit`/`byp1_hit`=0 and `byp0_data`/`byp1_data`=0 constantly. Decode must stall on pending writes. All other behaviour is identical.

## Test plan
- Single ALU write: push rd=5, data=0x0000_00A5 at edge 1 → `writeEnable`=1, `wRegNum`=5, `wDataIn`=0xA5 after edge 2; `reg_mem[5]`=0xA5 after edge 3; `occupancy` back to 0.
- Priority and x0: `ld_valid` rd=3/0x33 and `alu_valid` rd=4/0x44 in the same cycle → load accepted, `alu_ready`=0. Then ALU rd=0 → accepted with `occupancy` unchanged. Write order is 3, 4; x0 is never written.
- Full/wrap: `chip_en` gating pops, push rd=1..4 → `occupancy`=4 and both readies=0. Release and push rd=5..8 continuously → writes appear in order 1..8 with no loss or duplication.
- Bypass: queue rd=7/0x11 then rd=7/0x22, `regNum0`=7 → `byp0_hit`=1, `byp0_data`=0x22. `regNum1`=0 → `byp1_hit`=0. With the macro undefined, both hits are 0.
- Flush: 3 entries queued plus one in the output register, assert `flush` → the in-flight write completes, then `writeEnable`=0 and `occupancy`=0.
- Async reset: drop `reset` mid-stream between edges → outputs go to 0 immediately; after release, a fresh push rd=9/0x99 writes correctly.
